dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data port.
- Accepts one load/store request per handshake, inserts a programmable number of wait states, then returns read data and a status flag.
- Sits between the core's MemWrite/ALUResult/WriteData/ReadData port and the data storage.
- Replaces the zero-latency memory model so that multi-cycle and stalling cores can be exercised against a realistic responder.

Parameters:
- DEPTH, 64, number of 32-bit words stored; power of two, min 4.
- WAIT_CYCLES, 2, wait states between request acceptance and commit; 0..15.
- DATA_W, 32, data width; fixed at 32, byte lanes = DATA_W/8.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept a request.
- MemWrite  input  1  1 = store, 0 = load; sampled at acceptance.
- ALUResult  input  32  byte address; sampled at acceptance.
- WriteData  input  32  store data; sampled at acceptance.
- ByteEn  input  4  store byte-lane enables; sampled at acceptance; ignored for loads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  core consumes the response.
- ReadData  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous, active-low. It forces the FSM to IDLE, clears the wait counter and the latched request, and drives req_ready=1, rsp_valid=0, ReadData=0, rsp_err=0, busy=0. Storage contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid&req_ready: latch MemWrite, ALUResult, WriteData and ByteEn; load the wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0. Otherwise commit in the same cycle and go to RESP.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle.
  - When counter==1, commit and go to RESP on the next edge.
  - Total latency from the acceptance edge to rsp_valid high is WAIT_CYCLES+1 edges (1 edge when WAIT_CYCLES=0).
- Commit (one cycle only):
  - Error if latched address[1:0]!=0 or address>=DEPTH*4.
  - Error: no write, ReadData=0, rsp_err=1.
  - Store: for each i with ByteEn[i]=1, write byte i of WriteData into word address[log2(DEPTH)+1:2]. ReadData=0.
  - Load: ReadData = stored word. ByteEn has no effect on loads.
- RESP:
  - rsp_valid=1; ReadData and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: go to IDLE and clear rsp_valid, ReadData and rsp_err.
  - No back-to-back acceptance in the same cycle: a new request is accepted at the earliest in the IDLE cycle after consumption.
- Address rules: ALUResult bits above the storage index are checked only for the range error; there is no wrap-around aliasing.
- Simultaneous events: req_valid while busy is ignored, not queued. The core must hold req_valid and its request signals until req_ready. A request already accepted is not affected by later input changes.
- Reset mid-operation: a reset asserted in WAIT aborts the request with no write committed. A reset asserted in RESP discards the response; a store has already been committed.
- Store-then-load to the same word returns the stored data; there is no read-during-write hazard because accesses are serialised.

Decomposition:
- Package arm_mem_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - WORD_BYTES=4;
  - the error-check helper (misaligned/out-of-range function).
- One sub-module, dmem_array: a synchronous DEPTH x 32 storage with 4 byte-lane write enables and combinational read. dmem_responder holds the FSM, the counter and the request/response registers.

Test Plan:
- Reset low while driving requests → req_ready=1, rsp_valid=0, ReadData=0, busy=0. After release, the first request is accepted on the next edge.
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x10 with ByteEn=4'hF, then load 0x10 → each rsp_valid rises 3 edges after acceptance, rsp_err=0, load ReadData=0xDEADBEEF.
- Store 0x000000AA to 0x10 with ByteEn=4'b0001 over the word 0xDEADBEEF, then load 0x10 → ReadData=0xDEADBEAA.
- Load 0x12 (misaligned) and load DEPTH*4 (0x100) → rsp_err=1, ReadData=0. A following load of 0x10 is unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid → rsp_valid and ReadData stay stable, req_ready=0, nothing new is accepted. Raising rsp_ready returns the FSM to IDLE.
- WAIT_CYCLES=0 back-to-back loads, plus reset pulsed during WAIT of a store to 0x20 → 1-edge latency per load. The address 0x20 keeps its prior value after reset.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e  : responder FSM states
//   req_t    : one latched load/store request
//   addr_err : flags a misaligned or out-of-range byte address
package arm_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = 8 * WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic                  we;
    logic [WORD_W-1:0]     addr;
    logic [WORD_W-1:0]     wdata;
    logic [WORD_BYTES-1:0] be;
  } req_t;

  // Full address is compared against the storage size, so high address
  // bits never alias back onto a valid word.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                    input int unsigned       depth);
    return (addr[1:0] != 2'b00) || (addr >= 32'(depth * WORD_BYTES));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage: synchronous byte-lane write, combinational read.
//   clk   : write clock
//   we    : write strobe for this cycle
//   addr  : word index
//   be    : byte-lane enables for the write
//   wdata : write data
//   rdata : word currently addressed
module dmem_array
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; clearing a RAM would force it into flops and
  // its contents must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core data port with programmable wait states.
//   clk, reset          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake
//   MemWrite, ALUResult,
//   WriteData, ByteEn   : request fields, captured at acceptance
//   rsp_valid/rsp_ready : response handshake
//   ReadData, rsp_err   : response payload, held until consumed
//   busy                : high whenever not IDLE
module dmem_responder
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                MemWrite,
  input  logic [31:0]         ALUResult,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   ReadData,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  req_t              in_req, c_req;
  logic              c_bad, commit, mem_we;
  logic [WORD_W-1:0] mem_rdata;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (c_req.addr[AW+1:2]),
    .be    (c_req.be),
    .wdata (c_req.wdata),
    .rdata (mem_rdata)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    busy_d      = busy_q;
    commit      = 1'b0;
    mem_we      = 1'b0;

    in_req = '{we: MemWrite, addr: ALUResult, wdata: WriteData, be: ByteEn};
    // With zero wait states the commit happens in the acceptance cycle, so
    // the live inputs are the request; otherwise the latched copy is.
    c_req  = (state_q == WAIT) ? req_q : in_req;
    c_bad  = addr_err(c_req.addr, DEPTH);

    unique case (state_q)
      IDLE: begin
        // req_ready is high exactly in IDLE, so req_valid alone completes the handshake.
        if (req_valid) begin
          req_d       = in_req;
          cnt_d       = WAIT_INIT;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rdata_d     = '0;
          err_d       = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      mem_we      = c_req.we && !c_bad;
      rsp_valid_d = 1'b1;
      err_d       = c_bad;
      rdata_d     = (c_bad || c_req.we) ? '0 : mem_rdata;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign ReadData  = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none, sharing stimulus; sel chooses which one sees req_valid and
// whose outputs are observed.
module tb_dmem_responder;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        reset, req_valid, sel, MemWrite, rsp_ready;
  logic [31:0] ALUResult, WriteData;
  logic [3:0]  ByteEn;

  logic        rr_a, rv_a, er_a, bz_a, rr_b, rv_b, er_b, bz_b;
  logic [31:0] rd_a, rd_b;
  logic        o_rr, o_rv, o_err, o_busy;
  logic [31:0] o_rd;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W)) dut_w2 (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rr_a),
    .MemWrite(MemWrite), .ALUResult(ALUResult), .WriteData(WriteData),
    .ByteEn(ByteEn), .rsp_valid(rv_a), .rsp_ready(rsp_ready),
    .ReadData(rd_a), .rsp_err(er_a), .busy(bz_a)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rr_b),
    .MemWrite(MemWrite), .ALUResult(ALUResult), .WriteData(WriteData),
    .ByteEn(ByteEn), .rsp_valid(rv_b), .rsp_ready(rsp_ready),
    .ReadData(rd_b), .rsp_err(er_b), .busy(bz_b)
  );

  assign o_rr   = sel ? rr_b : rr_a;
  assign o_rv   = sel ? rv_b : rv_a;
  assign o_err  = sel ? er_b : er_a;
  assign o_busy = sel ? bz_b : bz_a;
  assign o_rd   = sel ? rd_b : rd_a;

  typedef struct {
    logic        s;       // 1 = zero-wait instance
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the request already on the inputs: accepts it,
  // scrambles the inputs, measures latency and consumes the response.
  task automatic finish_req(input string name, input int exp_lat,
                            input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(posedge clk);
    lat = 1;
    #1;
    check({name, " accepted busy/ready"}, {30'd0, o_busy, o_rr}, 32'd2);
    req_valid = 1'b0;
    MemWrite  = ~MemWrite;
    ALUResult = 32'hFFFF_FFF0;
    WriteData = 32'h5A5A_5A5A;
    ByteEn    = 4'hF;
    @(negedge clk);
    while (!o_rv && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " ReadData"}, o_rd, exp_rd);
    check({name, " rsp_err"}, {31'd0, o_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({name, " after consume v/err/busy/ready"}, {28'd0, o_rv, o_err, o_busy, o_rr}, 32'd1);
    check({name, " ReadData cleared"}, o_rd, 32'd0);
  endtask

  task automatic do_vec(input vec_t v, input string name);
    sel       = v.s;
    req_valid = 1'b1;
    MemWrite  = v.we;
    ALUResult = v.addr;
    WriteData = v.wdata;
    ByteEn    = v.be;
    finish_req(name, v.s ? 1 : W + 1, v.exp_rd, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   w;

    // Reset held while a store to 0x30 is presented.
    sel = 1'b0; rsp_ready = 1'b0; reset = 1'b0;
    req_valid = 1'b1; MemWrite = 1'b1; ALUResult = 32'h30;
    WriteData = 32'h1234_5678; ByteEn = 4'hF;
    repeat (3) @(negedge clk);
    check("reset req_ready", {31'd0, o_rr}, 32'd1);
    check("reset rsp_valid", {31'd0, o_rv}, 32'd0);
    check("reset ReadData", o_rd, 32'd0);
    check("reset rsp_err", {31'd0, o_err}, 32'd0);
    check("reset busy", {31'd0, o_busy}, 32'd0);
    reset = 1'b1;
    finish_req("first after reset", W + 1, 32'd0, 1'b0);

    vecs.push_back('{1'b0, 1'b1, 32'h10,        32'hDEAD_BEEF, 4'hF,    32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h10,        32'h0,         4'hF,    32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h10,        32'h0000_00AA, 4'b0001, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h10,        32'h0,         4'h0,    32'hDEAD_BEAA, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h12,        32'h0,         4'hF,    32'h0,         1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h100,       32'h0,         4'hF,    32'h0,         1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h10,        32'h0,         4'hF,    32'hDEAD_BEAA, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h30,        32'h0,         4'hF,    32'h1234_5678, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h12,        32'hFFFF_FFFF, 4'hF,    32'h0,         1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h10,        32'h0,         4'hF,    32'hDEAD_BEAA, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h20,        32'h1122_3344, 4'hF,    32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h20,        32'hCAFE_F00D, 4'b1010, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'h20,        32'h0,         4'hF,    32'hCA22_F044, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'hFC,        32'hA5A5_A5A5, 4'hF,    32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'hFC,        32'h0,         4'hF,    32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF,    32'h0,         1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h110,       32'h0,         4'hF,    32'h0,         1'b1});
    vecs.push_back('{1'b1, 1'b1, 32'h40,        32'h0BAD_F00D, 4'hF,    32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h44,        32'h55AA_55AA, 4'hF,    32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h40,        32'h0,         4'hF,    32'h0BAD_F00D, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h44,        32'h0,         4'hF,    32'h55AA_55AA, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h41,        32'h0,         4'hF,    32'h0,         1'b1});
    vecs.push_back('{1'b1, 1'b0, 32'h100,       32'h0,         4'hF,    32'h0,         1'b1});

    foreach (vecs[i]) do_vec(vecs[i], $sformatf("vec%0d", i));

    // Response stalled for 5 cycles while req_valid toggles.
    sel = 1'b0; req_valid = 1'b1; MemWrite = 1'b0; ALUResult = 32'h10; ByteEn = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!o_rv && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("stall rsp_valid reached", {31'd0, o_rv}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      req_valid = ~req_valid; MemWrite = 1'b1; ALUResult = 32'h30;
      @(negedge clk);
      check($sformatf("stall%0d v/ready", k), {30'd0, o_rv, o_rr}, 32'd2);
      check($sformatf("stall%0d ReadData", k), o_rd, 32'hDEAD_BEAA);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("stall release v/busy/ready", {29'd0, o_rv, o_busy, o_rr}, 32'd1);
    @(negedge clk);
    check("stall nothing queued busy", {31'd0, o_busy}, 32'd0);

    // Reset during WAIT of a store to 0x20 aborts it.
    req_valid = 1'b1; MemWrite = 1'b1; ALUResult = 32'h20;
    WriteData = 32'hFFFF_FFFF; ByteEn = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("wait reset busy/valid/ready", {29'd0, o_busy, o_rv, o_rr}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    v = '{1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 32'hCA22_F044, 1'b0};
    do_vec(v, "load 0x20 after aborted store");

    // Reset during RESP of a store: the write is already committed.
    req_valid = 1'b1; MemWrite = 1'b1; ALUResult = 32'h24;
    WriteData = 32'h7777_7777; ByteEn = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!o_rv && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("resp-reset rsp_valid reached", {31'd0, o_rv}, 32'd1);
    reset = 1'b0;
    #1;
    check("resp reset valid/busy", {30'd0, o_rv, o_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    v = '{1'b0, 1'b0, 32'h24, 32'h0, 4'hF, 32'h7777_7777, 1'b0};
    do_vec(v, "load 0x24 after resp reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
